// File: rtl/shared_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// shared_bus_rr_arbiter
// Round-robin arbiter sharing one bus/memory port among NUM_REQ requesters.
// Grants are registered (one-hot Grant plus binary GrantIndex). A grant is held
// while the owner keeps its request asserted. Each release is followed by one
// turnaround cycle. A rotating one-hot pointer gives every requester a turn.
// Optional macro ARB_TIMEOUT_EN adds a hold watchdog that revokes a grant
// after TIMEOUT cycles and raises a sticky TimeoutFlag.
// -----------------------------------------------------------------------------
module shared_bus_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2,
   parameter int TIMEOUT = 255
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic [NUM_REQ-1:0] Request,
   output logic [NUM_REQ-1:0] Grant,
   output logic [IDX_W-1:0]   GrantIndex,
   output logic               GrantValid,
   output logic               Busy,
   output logic               TimeoutFlag
);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_GRANT      = 2'd1,
      ST_TURNAROUND = 2'd2
   } state_t;

   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   // Parameter sanity checks, evaluated at elaboration time only.
   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $error("NUM_REQ must be in 2..16");
   end
   if (IDX_W < $clog2(NUM_REQ)) begin : g_bad_idx_w
      $error("IDX_W too narrow for NUM_REQ");
   end
   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("TIMEOUT must be in 1..65535");
   end

   state_t             r_state;
   logic [NUM_REQ-1:0] r_grant;
   logic [NUM_REQ-1:0] r_ptr;
   logic [IDX_W-1:0]   r_index;
   logic               r_valid;
   logic               r_busy;

   logic [NUM_REQ-1:0] w_masked_req;
   logic [NUM_REQ-1:0] w_pick_src;
   logic [NUM_REQ-1:0] w_win_onehot;
   logic [IDX_W-1:0]   w_win_idx;
   logic               w_owner_req;
   logic               w_timeout;

   // Requests at or above the pointer take priority; if none, wrap to the
   // lowest set request. Lowest set bit of x is x & -x.
   assign w_masked_req = Request & ~(r_ptr - ONE);
   assign w_pick_src   = (|w_masked_req) ? w_masked_req : Request;
   assign w_win_onehot = w_pick_src & (~w_pick_src + ONE);
   assign w_owner_req  = |(Request & r_grant);

   // Encode the one-hot winner to a binary index.
   always_comb begin
      // NOTE: default first so every path assigns the output; no latch is inferred.
      w_win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win_onehot[i]) w_win_idx = IDX_W'(i);
      end
   end

`ifdef ARB_TIMEOUT_EN
   logic [15:0] r_hold_cnt;
   logic [16:0] w_cnt_next;
   logic        r_timeout_flag;

   assign w_cnt_next = {1'b0, r_hold_cnt} + 17'd1;
   // Revoke on the edge where the grant has been visible for TIMEOUT cycles.
   assign w_timeout  = (r_state == ST_GRANT) && w_owner_req &&
                       (w_cnt_next >= 17'(TIMEOUT));

   // Hold counter restarts on each new grant; sticky flag on a revoke.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_hold_cnt     <= '0;
         r_timeout_flag <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && |Request) begin
            r_hold_cnt <= '0;
         end else if (r_state == ST_GRANT) begin
            r_hold_cnt <= w_cnt_next[15:0];
         end
         if (w_timeout) r_timeout_flag <= 1'b1;
      end
   end

   assign TimeoutFlag = r_timeout_flag;
`else
   assign w_timeout   = 1'b0;
   assign TimeoutFlag = 1'b0;
`endif

   // Arbitration state machine with registered grant outputs.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_index <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_ptr   <= ONE;
      end else begin
         // NOTE: non-blocking assignments so all state updates see pre-edge values.
         case (r_state)
            ST_IDLE: begin
               if (|Request) begin
                  r_state <= ST_GRANT;
                  r_grant <= w_win_onehot;
                  r_index <= w_win_idx;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_ptr   <= {w_win_onehot[NUM_REQ-2:0], w_win_onehot[NUM_REQ-1]};
               end
            end
            ST_GRANT: begin
               if (!w_owner_req || w_timeout) begin
                  r_state <= ST_TURNAROUND;
                  r_grant <= '0;
                  r_index <= '0;
                  r_valid <= 1'b0;
               end
            end
            ST_TURNAROUND: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= '0;
               r_index <= '0;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign Grant      = r_grant;
   assign GrantIndex = r_index;
   assign GrantValid = r_valid;
   assign Busy       = r_busy;

endmodule

// File: tb/tb_shared_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_bus_rr_arbiter
// Directed self-checking bench for shared_bus_rr_arbiter (NUM_REQ=4,
// TIMEOUT=8). Builds with or without ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_shared_bus_rr_arbiter;

   logic       Clock;
   logic       Reset;
   logic [3:0] Request;
   logic [3:0] Grant;
   logic [1:0] GrantIndex;
   logic       GrantValid;
   logic       Busy;
   logic       TimeoutFlag;

   int n_checks = 0;
   int n_errors = 0;

   shared_bus_rr_arbiter #(
      .NUM_REQ(4),
      .IDX_W  (2),
      .TIMEOUT(8)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Request    (Request),
      .Grant      (Grant),
      .GrantIndex (GrantIndex),
      .GrantValid (GrantValid),
      .Busy       (Busy),
      .TimeoutFlag(TimeoutFlag)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] idx,
                             input logic v, input logic b);
      check({tag, "_grant"}, 32'(Grant), 32'(g));
      check({tag, "_index"}, 32'(GrantIndex), 32'(idx));
      check({tag, "_valid"}, 32'(GrantValid), 32'(v));
      check({tag, "_busy"},  32'(Busy), 32'(b));
   endtask

   // Advance one rising edge, then settle away from the edge.
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      logic [3:0] req_all;
      int         order [5];

      order   = '{0, 1, 2, 3, 0};
      req_all = 4'b1111;

      // Reset state
      Reset   = 1'b0;
      Request = 4'b0000;
      #2 Reset = 1'b1;
      #1;
      check_outs("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      check("reset_tflag", 32'(TimeoutFlag), 32'd0);
      tick();
      tick();
      Reset = 1'b0;

      // Idle with no requests for 10 cycles
      for (int i = 0; i < 10; i++) begin
         tick();
         check_outs("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      end

      // 1010 from pointer bit0: requester 1, then turnaround, then requester 3
      Request = 4'b1010;
      tick();
      check_outs("r1010_first", 4'b0010, 2'd1, 1'b1, 1'b1);
      Request = 4'b1000;
      tick();
      check_outs("r1010_turn", 4'b0000, 2'd0, 1'b0, 1'b1);
      tick();
      check_outs("r1010_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      tick();
      check_outs("r1010_second", 4'b1000, 2'd3, 1'b1, 1'b1);
      Request = 4'b0000;
      tick();
      check_outs("r1000_turn", 4'b0000, 2'd0, 1'b0, 1'b1);
      tick();
      check_outs("r1000_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

      // All requesting; each owner drops for one cycle after 3 owned cycles
      Request = req_all;
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 3; c++) begin
            tick();
            check_outs($sformatf("rr%0d_own", k), 4'(4'b0001 << order[k]),
                       2'(order[k]), 1'b1, 1'b1);
         end
         Request = req_all & ~4'(4'b0001 << order[k]);
         tick();
         check_outs($sformatf("rr%0d_turn", k), 4'b0000, 2'd0, 1'b0, 1'b1);
         Request = req_all;
         tick();
         check_outs($sformatf("rr%0d_idle", k), 4'b0000, 2'd0, 1'b0, 1'b0);
      end
      Request = 4'b0000;
      tick();
      check_outs("rr_done", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Pointer wrap: grant to 3 ends, then 1001 picks requester 0
      Request = 4'b1000;
      tick();
      check_outs("wrap_own3", 4'b1000, 2'd3, 1'b1, 1'b1);
      Request = 4'b0000;
      tick();
      tick();
      Request = 4'b1001;
      tick();
      check_outs("wrap_own0", 4'b0001, 2'd0, 1'b1, 1'b1);
      Request = 4'b0000;
      tick();
      tick();

      // Asynchronous reset mid-grant
      Request = 4'b0100;
      tick();
      check_outs("areset_own2", 4'b0100, 2'd2, 1'b1, 1'b1);
      #2 Reset = 1'b1;
      #1;
      check_outs("areset_now", 4'b0000, 2'd0, 1'b0, 1'b0);
      tick();
      Reset = 1'b0;
      tick();
      check_outs("areset_regrant", 4'b0100, 2'd2, 1'b1, 1'b1);
      Request = 4'b0000;
      tick();
      tick();
      check_outs("areset_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Long hold with 0011 (pointer at bit3 -> wraps to requester 0)
      Request = 4'b0011;
      tick();
      check_outs("hold_first", 4'b0001, 2'd0, 1'b1, 1'b1);
      check("hold_first_tflag", 32'(TimeoutFlag), 32'd0);
`ifdef ARB_TIMEOUT_EN
      for (int i = 1; i < 8; i++) begin
         tick();
         check_outs($sformatf("to_hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b1);
         check($sformatf("to_hold%0d_tflag", i), 32'(TimeoutFlag), 32'd0);
      end
      tick();
      check_outs("to_revoke", 4'b0000, 2'd0, 1'b0, 1'b1);
      check("to_revoke_tflag", 32'(TimeoutFlag), 32'd1);
      tick();
      check_outs("to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      check("to_idle_tflag", 32'(TimeoutFlag), 32'd1);
      tick();
      check_outs("to_next", 4'b0010, 2'd1, 1'b1, 1'b1);
      check("to_next_tflag", 32'(TimeoutFlag), 32'd1);
`else
      for (int i = 1; i < 100; i++) begin
         tick();
         check_outs($sformatf("hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b1);
         check($sformatf("hold%0d_tflag", i), 32'(TimeoutFlag), 32'd0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
